lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store memory controller for the MEM stage of the RV32I core. It consumes the byte-select and size/sign flags produced by the alignment stage, runs one data-memory bus transaction per request over a req/ack handshake, and stalls the pipeline until the transaction completes. On loads it extracts and extends the addressed byte, halfword or word from the returned memory word. On stores it shifts the write data into the correct byte lanes.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: bus cycles to wait for `dmem_ack` before aborting with an error; range 1..255, held in an 8-bit counter.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  MEM-stage access request
- req_ready  out  1  request accepted this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, unshifted (rs2)
- wsel  in  4  byte-lane enables from the alignment stage
- W  in  1  word access
- HW  in  1  halfword access; byte access when W=HW=0
- unsign  in  1  1 = zero-extend load, 0 = sign-extend
- stall  out  1  freeze upstream pipeline
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores and errors)
- resp_err  out  1  misaligned or timed-out access, valid with resp_valid
- dmem_req  out  1  bus request
- dmem_we  out  1  bus write
- dmem_addr  out  32  word address: {req_addr[31:2],2'b00}
- dmem_be  out  4  bus byte enables
- dmem_wdata  out  32  lane-shifted store data
- dmem_ack  in  1  bus completion; dmem_rdata valid with it
- dmem_rdata  in  32  bus read word

## Operation
- States: IDLE, BUS, DONE.
- IDLE: `req_ready`=1. When `req_valid`=1, latch the address, data, flags and wsel, then go to BUS. With LSU_MISALIGN_TRAP_EN and a misaligned access, go to DONE with the error flag set instead.
- Misaligned: W with addr[1:0]≠0, or HW with addr[0]=1.
- BUS: hold `dmem_req`=1 and keep every dmem_* output stable until `dmem_ack`. On ack, capture `dmem_rdata` and go to DONE.
  - The timeout counter resets on entry to BUS and increments each BUS cycle without ack.
  - When the count reaches TIMEOUT_CYCLES, drop `dmem_req`, set the error flag and go to DONE.
  - If ack and timeout occur in the same cycle, ack wins and there is no error.
- DONE: `resp_valid`=1 for exactly one cycle, then IDLE.
- Store lanes: `dmem_be`=latched wsel. `dmem_wdata` is `req_wdata` shifted left by 8*addr[1:0] for byte, 16*addr[1] for halfword, and unshifted for word.
- Load path: `dmem_be`=4'b1111. The byte is rdata[8*addr[1:0]+:8] and the halfword is rdata[16*addr[1]+:16]. Extension is selected by `unsign`.
- `dmem_ack` outside BUS is ignored.
- `stall` = (IDLE and req_valid) or BUS. It is 0 in DONE so the pipeline advances with the response.

## Timing
- Reset values: state IDLE. `dmem_req`, `dmem_we`, `resp_valid`, `resp_err` and `stall` are 0. `dmem_addr`, `dmem_be`, `dmem_wdata` and `resp_rdata` are 0.
- Minimum latency: request accepted at edge 0, `dmem_req` high in cycle 1. Ack in cycle 1 gives `resp_valid` in cycle 2.
- Timeout: with no ack, `dmem_req` is high for TIMEOUT_CYCLES cycles. `resp_valid`/`resp_err` follow in the next cycle.
- Reset mid-transaction: the FSM returns to IDLE at the next edge, `dmem_req` drops, and no response is issued.
- Back-to-back requests: a new request is accepted in the IDLE cycle after DONE. Throughput is at most one access per 3 cycles.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned accesses complete in DONE one cycle after acceptance with `resp_err`=1 and no bus transaction.
- Undefined: no check is made. The access proceeds using `dmem_addr` word alignment and the same lane rules. Only timeouts raise `resp_err`.

## Test plan
- Signed byte load at addr 0x1003 with rdata 0x80AB_CDEF, ack after 1 cycle: resp_rdata = 0xFFFF_FF80, resp_valid in cycle 2, stall low in cycle 2.
- Unsigned halfword load at addr 0x2002 with rdata 0x8001_1234: resp_rdata = 0x0000_8001.
- Byte store of 0x0000_00A5 at addr 0x3001 with wsel=4'b0010: dmem_wdata = 0x0000_A500, dmem_be = 4'b0010, dmem_addr = 0x3000.
- No ack with TIMEOUT_CYCLES=4: dmem_req high for exactly 4 cycles, then resp_valid=1 and resp_err=1.
- Word load at addr 0x4002: with LSU_MISALIGN_TRAP_EN, resp_err=1 and dmem_req never asserts. Without it, a bus read to 0x4000 completes normally.
- Reset asserted in the second BUS cycle: dmem_req=0 and state IDLE at the next edge, no resp_valid. A following request completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl_if.sv
// Purpose : Bundles for the load/store controller.
//   lsu_req_if  - MEM-stage request/response channel (pipeline is master).
//   lsu_dmem_if - data-memory req/ack bus (controller is master).
// Ports   : none. All signals are carried through the master/slave modports.
// ---------------------------------------------------------------------------

interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  wsel;
    logic        W;
    logic        HW;
    logic        unsign;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, wsel, W, HW, unsign,
        input  req_ready, stall, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, wsel, W, HW, unsign,
        output req_ready, stall, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_dmem_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl.sv
// Purpose : MEM-stage load/store controller. Runs one data-memory bus
//           transaction per request, stalls the pipeline meanwhile, extends
//           load data and lane-shifts store data.
// Ports   :
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   req   - lsu_req_if.slave  : request (addr/data/wsel/W/HW/unsign),
//                               req_ready, stall, resp_valid/rdata/err
//   dmem  - lsu_dmem_if.master: dmem_req/we/addr/be/wdata, dmem_ack/rdata
// Parameter : TIMEOUT_CYCLES (1..255) bus cycles to wait for dmem_ack.
// Option    : define LSU_MISALIGN_TRAP_EN to fail misaligned accesses
//             without a bus transaction.
// ---------------------------------------------------------------------------

module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    lsu_req_if.slave   req,
    lsu_dmem_if.master dmem
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       lat_lo_q;
    logic             lat_w_q;
    logic             lat_hw_q;
    logic             lat_unsign_q;
    logic             err_q;
    logic [31:0]      rdata_q;
    logic             dmem_we_q;
    logic [31:0]      dmem_addr_q;
    logic [3:0]       dmem_be_q;
    logic [31:0]      dmem_wdata_q;

    logic        ready_c;
    logic        stall_c;
    logic        resp_valid_c;
    logic        dmem_req_c;
    logic        accept_c;
    logic        trap_c;
    logic        ack_c;
    logic        timeout_c;
    logic [31:0] store_data_c;
    logic [31:0] load_data_c;
    logic [7:0]  load_byte_c;
    logic [15:0] load_half_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_d      = state_q;
        ready_c      = 1'b0;
        stall_c      = 1'b0;
        resp_valid_c = 1'b0;
        dmem_req_c   = 1'b0;
        accept_c     = 1'b0;
        trap_c       = 1'b0;
        ack_c        = 1'b0;
        timeout_c    = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                stall_c = req.req_valid;
                if (req.req_valid) begin
                    accept_c = 1'b1;
                    state_d  = BUS;
`ifdef LSU_MISALIGN_TRAP_EN
                    if ((req.W && (req.req_addr[1:0] != 2'b00)) ||
                        (req.HW && req.req_addr[0])) begin
                        trap_c  = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            BUS: begin
                stall_c    = 1'b1;
                dmem_req_c = 1'b1;
                // Ack takes priority over a coincident timeout
                if (dmem.dmem_ack) begin
                    ack_c   = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_c = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                resp_valid_c = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Store lane shift from the live request
    always_comb begin
        store_data_c = req.req_wdata;
        if (!req.W) begin
            if (req.HW) begin
                store_data_c = req.req_wdata << {req.req_addr[1], 4'b0000};
            end else begin
                store_data_c = req.req_wdata << {req.req_addr[1:0], 3'b000};
            end
        end
    end

    // Load lane select and extension from the latched flags
    always_comb begin
        load_byte_c = dmem.dmem_rdata[{lat_lo_q, 3'b000} +: 8];
        load_half_c = dmem.dmem_rdata[{lat_lo_q[1], 4'b0000} +: 16];
        load_data_c = dmem.dmem_rdata;
        if (!lat_w_q) begin
            if (lat_hw_q) begin
                load_data_c = {{16{~lat_unsign_q & load_half_c[15]}}, load_half_c};
            end else begin
                load_data_c = {{24{~lat_unsign_q & load_byte_c[7]}}, load_byte_c};
            end
        end
    end

    // Request latch, timeout counter and response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            lat_lo_q     <= '0;
            lat_w_q      <= 1'b0;
            lat_hw_q     <= 1'b0;
            lat_unsign_q <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= '0;
            dmem_wdata_q <= '0;
        end else begin
            if (accept_c) begin
                cnt_q        <= '0;
                lat_lo_q     <= req.req_addr[1:0];
                lat_w_q      <= req.W;
                lat_hw_q     <= req.HW;
                lat_unsign_q <= req.unsign;
                err_q        <= trap_c;
                rdata_q      <= '0;
                dmem_we_q    <= req.req_we;
                dmem_addr_q  <= {req.req_addr[31:2], 2'b00};
                dmem_be_q    <= req.req_we ? req.wsel : 4'b1111;
                dmem_wdata_q <= store_data_c;
            end
            if (state_q == BUS && !dmem.dmem_ack) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (ack_c) begin
                rdata_q <= dmem_we_q ? 32'h0 : load_data_c;
            end
            if (timeout_c) begin
                err_q <= 1'b1;
            end
        end
    end

    assign req.req_ready   = ready_c;
    assign req.stall       = stall_c;
    assign req.resp_valid  = resp_valid_c;
    assign req.resp_rdata  = rdata_q;
    assign req.resp_err    = err_q;
    assign dmem.dmem_req   = dmem_req_c;
    assign dmem.dmem_we    = dmem_we_q;
    assign dmem.dmem_addr  = dmem_addr_q;
    assign dmem.dmem_be    = dmem_be_q;
    assign dmem.dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_ctrl.sv
// Purpose : Directed self-checking bench for lsu_mem_ctrl (TIMEOUT_CYCLES=4).
// Ports   : none (top-level bench).
// ---------------------------------------------------------------------------

module tb_lsu_mem_ctrl;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   hi_cnt;

    lsu_req_if  rif ();
    lsu_dmem_if dif ();

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (rif),
        .dmem  (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns #1 after the accepting edge
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wsel, input logic w, input logic hw, input logic uns);
        rif.req_we    = we;
        rif.req_addr  = addr;
        rif.req_wdata = wdata;
        rif.wsel      = wsel;
        rif.W         = w;
        rif.HW        = hw;
        rif.unsign    = uns;
        rif.req_valid = 1'b1;
        #1;
        check("stall_on_req", 32'(rif.stall), 32'd1);
        @(posedge clk); #1;
        rif.req_valid = 1'b0;
    endtask

    // Ack for one cycle with the given read word; returns #1 after that edge
    task automatic ack_with(input logic [31:0] rdata);
        dif.dmem_ack   = 1'b1;
        dif.dmem_rdata = rdata;
        @(posedge clk); #1;
        dif.dmem_ack   = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        rif.req_valid = 1'b0;
        rif.req_we    = 1'b0;
        rif.req_addr  = '0;
        rif.req_wdata = '0;
        rif.wsel      = '0;
        rif.W         = 1'b0;
        rif.HW        = 1'b0;
        rif.unsign    = 1'b0;
        dif.dmem_ack   = 1'b0;
        dif.dmem_rdata = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_dmem_req", 32'(dif.dmem_req), 32'd0);
        check("rst_resp_valid", 32'(rif.resp_valid), 32'd0);
        check("rst_stall", 32'(rif.stall), 32'd0);
        check("rst_dmem_addr", dif.dmem_addr, 32'h0);
        check("rst_resp_rdata", rif.resp_rdata, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", 32'(rif.req_ready), 32'd1);

        // Signed byte load at 0x1003, ack in cycle 1
        issue(1'b0, 32'h0000_1003, 32'h0, 4'b1000, 1'b0, 1'b0, 1'b0);
        check("lb_dmem_req", 32'(dif.dmem_req), 32'd1);
        check("lb_dmem_addr", dif.dmem_addr, 32'h0000_1000);
        check("lb_dmem_be", 32'(dif.dmem_be), 32'hF);
        check("lb_dmem_we", 32'(dif.dmem_we), 32'd0);
        ack_with(32'h80AB_CDEF);
        check("lb_resp_valid", 32'(rif.resp_valid), 32'd1);
        check("lb_rdata", rif.resp_rdata, 32'hFFFF_FF80);
        check("lb_err", 32'(rif.resp_err), 32'd0);
        check("lb_stall_done", 32'(rif.stall), 32'd0);
        @(posedge clk); #1;
        check("lb_pulse_end", 32'(rif.resp_valid), 32'd0);

        // Unsigned halfword load at 0x2002
        issue(1'b0, 32'h0000_2002, 32'h0, 4'b1100, 1'b0, 1'b1, 1'b1);
        ack_with(32'h8001_1234);
        check("lhu_rdata", rif.resp_rdata, 32'h0000_8001);
        @(posedge clk); #1;

        // Signed halfword load at 0x2000 (positive)
        issue(1'b0, 32'h0000_2000, 32'h0, 4'b0011, 1'b0, 1'b1, 1'b0);
        ack_with(32'h8001_7234);
        check("lh_rdata", rif.resp_rdata, 32'h0000_7234);
        @(posedge clk); #1;

        // Byte store 0xA5 at 0x3001
        issue(1'b1, 32'h0000_3001, 32'h0000_00A5, 4'b0010, 1'b0, 1'b0, 1'b0);
        check("sb_wdata", dif.dmem_wdata, 32'h0000_A500);
        check("sb_be", 32'(dif.dmem_be), 32'h2);
        check("sb_addr", dif.dmem_addr, 32'h0000_3000);
        check("sb_we", 32'(dif.dmem_we), 32'd1);
        ack_with(32'hFFFF_FFFF);
        check("sb_rdata_zero", rif.resp_rdata, 32'h0);
        @(posedge clk); #1;

        // Halfword store 0xBEEF at 0x3002
        issue(1'b1, 32'h0000_3002, 32'h1234_BEEF, 4'b1100, 1'b0, 1'b1, 1'b0);
        check("sh_wdata", dif.dmem_wdata, 32'hBEEF_0000);
        check("sh_be", 32'(dif.dmem_be), 32'hC);
        ack_with(32'h0);
        @(posedge clk); #1;

        // Ack outside BUS is ignored
        dif.dmem_ack = 1'b1;
        @(posedge clk); #1;
        dif.dmem_ack = 1'b0;
        check("stray_ack_valid", 32'(rif.resp_valid), 32'd0);
        check("stray_ack_req", 32'(dif.dmem_req), 32'd0);

        // Timeout: no ack, dmem_req high for exactly 4 cycles
        issue(1'b0, 32'h0000_5000, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0);
        hi_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (rif.resp_valid) break;
            if (dif.dmem_req) hi_cnt++;
            @(posedge clk); #1;
        end
        check("to_req_cycles", 32'(hi_cnt), 32'd4);
        check("to_resp_valid", 32'(rif.resp_valid), 32'd1);
        check("to_err", 32'(rif.resp_err), 32'd1);
        check("to_rdata", rif.resp_rdata, 32'h0);
        check("to_req_low", 32'(dif.dmem_req), 32'd0);
        @(posedge clk); #1;

        // Ack in the same cycle the timeout would fire: ack wins
        issue(1'b0, 32'h0000_6000, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check("late_ack_req", 32'(dif.dmem_req), 32'd1);
        ack_with(32'hDEAD_BEEF);
        check("late_ack_valid", 32'(rif.resp_valid), 32'd1);
        check("late_ack_err", 32'(rif.resp_err), 32'd0);
        check("late_ack_rdata", rif.resp_rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // Misaligned word load at 0x4002
        issue(1'b0, 32'h0000_4002, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_no_req", 32'(dif.dmem_req), 32'd0);
        check("mis_valid", 32'(rif.resp_valid), 32'd1);
        check("mis_err", 32'(rif.resp_err), 32'd1);
`else
        check("mis_req", 32'(dif.dmem_req), 32'd1);
        check("mis_addr", dif.dmem_addr, 32'h0000_4000);
        ack_with(32'h1122_3344);
        check("mis_valid", 32'(rif.resp_valid), 32'd1);
        check("mis_err", 32'(rif.resp_err), 32'd0);
        check("mis_rdata", rif.resp_rdata, 32'h1122_3344);
`endif
        @(posedge clk); #1;

        // Reset during the second BUS cycle
        issue(1'b0, 32'h0000_7000, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("rst_mid_bus", 32'(dif.dmem_req), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_req", 32'(dif.dmem_req), 32'd0);
        check("rst_mid_ready", 32'(rif.req_ready), 32'd1);
        check("rst_mid_valid", 32'(rif.resp_valid), 32'd0);
        @(posedge clk); #1;
        check("rst_mid_valid2", 32'(rif.resp_valid), 32'd0);

        // Following request completes normally: signed byte at lane 0
        issue(1'b0, 32'h0000_7000, 32'h0, 4'b0001, 1'b0, 1'b0, 1'b0);
        ack_with(32'h1234_56F0);
        check("post_rst_valid", 32'(rif.resp_valid), 32'd1);
        check("post_rst_rdata", rif.resp_rdata, 32'hFFFF_FFF0);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
